// File: rtl/barrel_step_shifter.sv
// rtl/barrel_step_shifter.sv - multi-mode N-bit shift register with single-step and burst operation
module barrel_step_shifter #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic [N-1:0]  I,
  input  logic [2:0]    Op,
  input  logic          W,
  input  logic [AW-1:0] Amount,
  input  logic          Start,
  output logic [N-1:0]  Q,
  output logic          SerialOut,
  output logic          Busy,
  output logic          Done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_SLL  = 3'd1;
  localparam logic [2:0] OP_SRL  = 3'd2;
  localparam logic [2:0] OP_LOAD = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_SRA  = 3'd6;

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic          so_q, so_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    opr_q, opr_d;

  logic [2:0]    sel_op;
  logic [N-1:0]  step_q;
  logic          step_so;
  logic          start_burst;

  // Only shift/rotate ops can start a burst; hold, load and reserved run as a single step.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_ROL) ||
           (op == OP_ROR) || (op == OP_SRA);
  endfunction

  // During a burst the captured op drives the datapath; otherwise the live Op does.
  always_comb begin
    sel_op      = (state_q == S_RUN) ? opr_q : Op;
    start_burst = Start && is_shift_op(Op);
  end

  // One step of the datapath for the selected op; bit loops keep N=1 legal.
  always_comb begin
    step_q  = q_q;
    step_so = so_q;
    case (sel_op)
      OP_SLL: begin
        step_so   = q_q[N-1];
        step_q[0] = W;
        for (int i = 1; i < N; i++) step_q[i] = q_q[i-1];
      end
      OP_SRL: begin
        step_so     = q_q[0];
        step_q[N-1] = W;
        for (int i = 0; i < N-1; i++) step_q[i] = q_q[i+1];
      end
      OP_LOAD: begin
        step_q = I;
      end
      OP_ROL: begin
        step_so   = q_q[N-1];
        step_q[0] = q_q[N-1];
        for (int i = 1; i < N; i++) step_q[i] = q_q[i-1];
      end
      OP_ROR: begin
        step_so     = q_q[0];
        step_q[N-1] = q_q[0];
        for (int i = 0; i < N-1; i++) step_q[i] = q_q[i+1];
      end
      OP_SRA: begin
        step_so     = q_q[0];
        step_q[N-1] = q_q[N-1];
        for (int i = 0; i < N-1; i++) step_q[i] = q_q[i+1];
      end
      default: begin
        step_q  = q_q;
        step_so = so_q;
      end
    endcase
  end

  // Next-state logic: single steps in IDLE, counted steps in RUN, one idle DONE cycle.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    so_d    = so_q;
    cnt_d   = cnt_q;
    opr_d   = opr_q;
    case (state_q)
      S_IDLE: begin
        if (start_burst) begin
          if (Amount != '0) begin
            opr_d   = Op;
            cnt_d   = Amount;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          q_d  = step_q;
          so_d = step_so;
        end
      end
      S_RUN: begin
        q_d   = step_q;
        so_d  = step_so;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset that also aborts a burst.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      cnt_q   <= '0;
      opr_q   <= OP_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      cnt_q   <= cnt_d;
      opr_q   <= opr_d;
    end
  end

  assign Q         = q_q;
  assign SerialOut = so_q;
  assign Busy      = (state_q == S_RUN);
  assign Done      = (state_q == S_DONE);

endmodule

// File: tb/tb_barrel_step_shifter.sv
// tb/tb_barrel_step_shifter.sv - self-checking bench for barrel_step_shifter
module tb_barrel_step_shifter;

  logic       Clock;
  logic       Reset;
  logic [7:0] I;
  logic [2:0] Op;
  logic       W;
  logic [2:0] Amount;
  logic       Start;
  logic [7:0] Q;
  logic       SerialOut;
  logic       Busy;
  logic       Done;

  int checks = 0;
  int errors = 0;

  // Reference model: register value, serial bit, remaining burst steps, pending Done.
  int m_q;
  int m_so;
  int m_rem;
  int m_op;
  int m_done;

  barrel_step_shifter #(.N(8), .AW(3)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .I(I),
    .Op(Op),
    .W(W),
    .Amount(Amount),
    .Start(Start),
    .Q(Q),
    .SerialOut(SerialOut),
    .Busy(Busy),
    .Done(Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic apply_op(input int op, input int w, input int din);
    case (op)
      1: begin m_so = (m_q >> 7) & 1; m_q = ((m_q << 1) | w) & 255; end
      2: begin m_so = m_q & 1; m_q = (m_q >> 1) | (w << 7); end
      3: m_q = din & 255;
      4: begin m_so = (m_q >> 7) & 1; m_q = ((m_q << 1) | (m_q >> 7)) & 255; end
      5: begin m_so = m_q & 1; m_q = (m_q >> 1) | ((m_q & 1) << 7); end
      6: begin m_so = m_q & 1; m_q = (m_q >> 1) | (m_q & 128); end
      default: ;
    endcase
  endtask

  task automatic model_edge();
    int op;
    op = int'(Op);
    if (!Reset) begin
      m_q = 0; m_so = 0; m_rem = 0; m_done = 0;
    end else if (m_done != 0) begin
      m_done = 0;
    end else if (m_rem > 0) begin
      apply_op(m_op, int'(W), 0);
      m_rem = m_rem - 1;
      if (m_rem == 0) m_done = 1;
    end else if (Start && (op == 1 || op == 2 || op == 4 || op == 5 || op == 6)) begin
      if (Amount != 0) begin
        m_op  = op;
        m_rem = int'(Amount);
      end else begin
        m_done = 1;
      end
    end else begin
      apply_op(op, int'(W), int'(I));
    end
  endtask

  task automatic check_model();
    checks++;
    assert (Q === 8'(m_q)) else begin
      errors++; $error("FAIL q obs=%h exp=%h t=%0t", Q, 8'(m_q), $time);
    end
    checks++;
    assert (SerialOut === 1'(m_so)) else begin
      errors++; $error("FAIL serial_out obs=%b exp=%b t=%0t", SerialOut, 1'(m_so), $time);
    end
    checks++;
    assert (Busy === (m_rem > 0)) else begin
      errors++; $error("FAIL busy obs=%b exp=%b t=%0t", Busy, (m_rem > 0), $time);
    end
    checks++;
    assert (Done === (m_done != 0)) else begin
      errors++; $error("FAIL done obs=%b exp=%b t=%0t", Done, (m_done != 0), $time);
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge Clock);
    #1;
    check_model();
  endtask

  task automatic expect_lit(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++; $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] op, input logic [7:0] din, input logic w,
                        input logic [2:0] amt, input logic st);
    Op = op; I = din; W = w; Amount = amt; Start = st;
  endtask

  initial begin
    m_q = 0; m_so = 0; m_rem = 0; m_op = 0; m_done = 0;

    // Reset with competing inputs active
    Reset = 1'b0;
    set_in(3'd3, 8'hA5, 1'b0, 3'd0, 1'b1);
    cycle();
    cycle();
    expect_lit("rst_q", Q, 8'h00);
    expect_lit("rst_flags", {5'd0, SerialOut, Busy, Done}, 8'h00);
    Reset = 1'b1;
    set_in(3'd3, 8'hA5, 1'b0, 3'd0, 1'b0);
    cycle();
    expect_lit("load_a5", Q, 8'hA5);

    // Single steps
    set_in(3'd3, 8'h96, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd1, 8'h00, 1'b1, 3'd0, 1'b0); cycle();
    expect_lit("sll_q", Q, 8'h2D);
    expect_lit("sll_so", {7'd0, SerialOut}, 8'h01);
    set_in(3'd3, 8'h80, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd6, 8'h00, 1'b0, 3'd0, 1'b0); cycle();
    expect_lit("sra_q", Q, 8'hC0);
    expect_lit("sra_so", {7'd0, SerialOut}, 8'h00);
    set_in(3'd3, 8'h01, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd5, 8'h00, 1'b0, 3'd0, 1'b0); cycle();
    expect_lit("ror_q", Q, 8'h80);
    expect_lit("ror_so", {7'd0, SerialOut}, 8'h01);

    // Burst rotate left by 3
    set_in(3'd3, 8'h81, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd4, 8'h00, 1'b0, 3'd3, 1'b1); cycle();
    expect_lit("burst_accept", {6'd0, Busy, Done}, 8'h02);
    set_in(3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    cycle(); expect_lit("burst_s1", Q, 8'h03);
    cycle(); expect_lit("burst_s2", Q, 8'h06);
    cycle(); expect_lit("burst_s3", Q, 8'h0C);
    expect_lit("burst_done", {5'd0, SerialOut, Busy, Done}, 8'h01);
    cycle();
    expect_lit("burst_idle", {6'd0, Busy, Done}, 8'h00);

    // Zero amount and non-shift Start
    set_in(3'd2, 8'h00, 1'b0, 3'd0, 1'b1); cycle();
    expect_lit("zero_amt", {Q[5:0], Busy, Done}, {6'h0C >> 0 & 6'h3F, 1'b0, 1'b1});
    set_in(3'd0, 8'h00, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd3, 8'h3C, 1'b0, 3'd0, 1'b1); cycle();
    expect_lit("load_start", Q, 8'h3C);
    expect_lit("load_nodone", {6'd0, Busy, Done}, 8'h00);

    // Input isolation during RUN
    set_in(3'd3, 8'hF0, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd2, 8'h00, 1'b0, 3'd4, 1'b1); cycle();
    set_in(3'd3, 8'h00, 1'b0, 3'd7, 1'b1);
    for (int k = 0; k < 4; k++) cycle();
    expect_lit("iso_q", Q, 8'h0F);
    expect_lit("iso_done", {6'd0, Busy, Done}, 8'h01);
    cycle();
    set_in(3'd0, 8'h00, 1'b0, 3'd0, 1'b0); cycle();

    // Reset mid-burst, then a fresh burst
    set_in(3'd3, 8'hFF, 1'b0, 3'd0, 1'b0); cycle();
    set_in(3'd2, 8'h00, 1'b0, 3'd7, 1'b1); cycle();
    set_in(3'd0, 8'h00, 1'b0, 3'd0, 1'b0);
    cycle(); cycle();
    expect_lit("abort_pre", Q, 8'h3F);
    Reset = 1'b0; cycle();
    expect_lit("abort_q", Q, 8'h00);
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) cycle();
    set_in(3'd1, 8'h00, 1'b1, 3'd2, 1'b1); cycle();
    expect_lit("restart_busy", {6'd0, Busy, Done}, 8'h02);
    set_in(3'd0, 8'h00, 1'b1, 3'd0, 1'b0);
    for (int k = 0; k < 3; k++) cycle();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      Reset  = ($urandom_range(0, 63) != 0);
      Op     = 3'($urandom_range(0, 7));
      I      = 8'($urandom);
      W      = 1'($urandom);
      Amount = 3'($urandom_range(0, 7));
      Start  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/barrel_step_shifter.md
# barrel_step_shifter

Parametrised, multi-mode shift register for the RiskV datapath. It replaces the fixed hold/left/right/load register with an N-bit unit that adds rotates, arithmetic right shift and a serial-out bit. It also has a multi-cycle burst mode that shifts by a programmable amount under a Start/Busy/Done handshake. The multi-cycle SLL/SRL/SRA path of the ALU sequencer drives it, and it is also used as a general-purpose serializer.

## Interface
Parameters:
- N, default 8: register width, N ≥ 1.
- AW, default 3: width of Amount. Maximum burst length is 2^AW−1 steps.

Ports:
- Clock  in  1: single clock. All state updates on the rising edge.
- Reset  in  1: synchronous, active-low. Sampled on the rising edge of Clock.
- I  in  N: parallel load data.
- Op  in  3: 0 hold, 1 shift left (W into bit 0), 2 shift right (W into bit N−1), 3 load I, 4 rotate left, 5 rotate right, 6 arithmetic right (bit N−1 replicated), 7 reserved, treated as hold.
- W  in  1: serial input for Op 1/2.
- Amount  in  AW: burst step count, captured on Start.
- Start  in  1: burst request.
- Q  out  N: register contents.
- SerialOut  out  1: last bit shifted or rotated out (registered).
- Busy  out  1: burst in progress.
- Done  out  1: one-cycle burst-completion pulse.

## Operation
- States: IDLE, RUN, DONE. State, Q, SerialOut and the step counter Cnt (AW bits) are registers. Busy = (state==RUN). Done = (state==DONE).
- IDLE, Start=0: apply Op as a single step at each edge. This is the legacy behaviour plus Ops 4–6.
- IDLE, Start=1, Op ∈ {1,2,4,5,6}, Amount>0: Q unchanged. Capture Op into OpR. Cnt ← Amount. State goes to RUN.
- IDLE, Start=1, Op ∈ {1,2,4,5,6}, Amount=0: Q unchanged, state goes to DONE.
- IDLE, Start=1, Op ∈ {0,3,7}: Start is ignored and Op executes as a single step.
- RUN: each edge applies OpR once and Cnt ← Cnt−1. On the edge where Cnt==1, state goes to DONE.
  - Op, Amount, I and Start are ignored while in RUN.
  - W is sampled live at every step.
- DONE: lasts exactly one cycle, then state goes to IDLE. All inputs except Reset are ignored, including Start and single-step Op.
- SerialOut updates only on a shift or rotate step:
  - Op 1 and 4: old Q[N−1].
  - Op 2, 5 and 6: old Q[0].
- SerialOut holds its value on hold, load and reserved ops.
- N=1: rotates leave Q unchanged but still update SerialOut. ASR leaves Q unchanged.
- A burst of ≥N steps with Op 1/2 fills Q entirely with W history. No saturation or special-casing.

## Timing
- Reset=0 at an edge forces Q=0, SerialOut=0, Cnt=0 and state IDLE, so Busy=0 and Done=0. Reset overrides every other input and every state, including mid-RUN. An aborted burst produces no Done pulse.
- Single-step latency: Q reflects Op one edge after it is presented.
- Burst accepted at edge k:
  - Busy is high from after edge k through edge k+Amount, for Amount cycles total.
  - Shifts occur at edges k+1 … k+Amount.
  - Done is high for the single cycle following edge k+Amount.
  - IDLE resumes after edge k+Amount+1.
- Burst with Amount=0 accepted at edge k: Done is high in the cycle after edge k. Busy never rises.
- The earliest next Start is sampled in IDLE, one cycle after Done.
- All outputs come directly from registers or from a decode of the state register only. There is no combinational path from inputs to outputs.

## Test plan
Parameters for all scenarios: N=8, AW=3.
1. Reset: hold Reset=0 with Op=3, I=8'hA5, Start=1 → Q=0, SerialOut=0, Busy=0, Done=0. Release Reset, apply Op=3 → Q=8'hA5 after one edge.
2. Single steps:
   - Q=8'b1001_0110, Op=1, W=1 → Q=8'b0010_1101, SerialOut=1.
   - Q=8'h80, Op=6 → Q=8'hC0, SerialOut=0.
   - Q=8'h01, Op=5 → Q=8'h80, SerialOut=1.
3. Burst rotate: Q=8'h81, Start with Op=4, Amount=3 → Busy high for exactly 3 cycles, Q steps 03, 06, 0C. Then Done pulses for 1 cycle with final Q=8'h0C, SerialOut=0.
4. Zero amount and non-shift Start:
   - Start with Op=2, Amount=0 → Busy stays 0, Done pulses in the next cycle, Q unchanged.
   - Start with Op=3, I=8'h3C → Q=8'h3C, no Done.
5. Input isolation: Q=8'hF0, Start with Op=2, W=0, Amount=4. During RUN, drive Op=3, I=8'h00, Start=1 → ignored. Final Q=8'h0F, then a single Done.
6. Reset mid-burst: Q=8'hFF, Start with Op=2, Amount=7, W=0. Pull Reset low after 2 steps → Q=0, Busy=0, and no Done pulse follows. A new Start in IDLE is then accepted normally.
